game_countdown_timer: RTL and testbench

Parametrised game-clock countdown. It holds remaining game time in seconds and decrements once per second from an internal prescaler. It supports start, pause/resume, and saturating bonus/penalty adjustments. It flags low time and expiry to the game FSM and the display path.

---
 rtl/game_timer_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 39 +++
 rtl/game_countdown_timer.sv | 112 +++++++++++
 tb/tb_game_countdown_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types, constants and arithmetic helpers for the game countdown timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int unsigned DEFAULT_TICK_DIV = 100000000;

  // Clamp a signed intermediate into [0, hi]; the timer never wraps.
  function automatic int sat_clamp(input int v, input int hi);
    if (v < 0) begin
      return 0;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that pulses tick_o on the last cycle of each TICK_DIV-cycle period.
module tick_prescaler
  import game_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] LastVal = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LastVal) ? '0 : cnt_q + 1'b1;
    end
  end

  // Holding en_i low freezes the count so a paused period resumes where it left off.
  assign tick_o = en_i && !clr_i && (cnt_q == LastVal);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Game clock: counts remaining seconds down with pause, saturating bonus/penalty and expiry flags.
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned INIT        = 20,
  parameter int unsigned MAX         = 255,
  parameter int unsigned TICK_DIV    = DEFAULT_TICK_DIV,
  parameter int unsigned STEP_W      = 4,
  parameter int unsigned WARN_THRESH = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              adj_up_i,
  input  logic              adj_down_i,
  input  logic [STEP_W-1:0] adj_amt_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              running_o,
  output logic              paused_o,
  output logic              expired_o,
  output logic              expired_pulse_o,
  output logic              sec_tick_o,
  output logic              warn_o
);

  localparam int unsigned SumW = WIDTH + STEP_W + 2;

  timer_state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic expired_pulse_q, expired_pulse_d;
  logic sec_tick_q, sec_tick_d;
  logic tick, presc_en;
  logic signed [SumW-1:0] delta, sum;

  assign presc_en = (state_q == RUNNING) && !pause_i && !start_i;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (presc_en),
    .clr_i (start_i),
    .tick_o(tick)
  );

  // Both flags together cancel out, as in the legacy controller.
  always_comb begin
    delta = '0;
    if (adj_up_i && !adj_down_i) begin
      delta = signed'(SumW'(adj_amt_i));
    end else if (!adj_up_i && adj_down_i) begin
      delta = -signed'(SumW'(adj_amt_i));
    end
    sum = signed'(SumW'(count_q)) - signed'(SumW'(tick)) + delta;
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    expired_pulse_d = 1'b0;
    sec_tick_d      = 1'b0;
    if (start_i) begin
      state_d = RUNNING;
      count_d = WIDTH'(INIT);
    end else begin
      unique case (state_q)
        IDLE: count_d = WIDTH'(INIT);
        RUNNING, PAUSED: begin
          sec_tick_d = tick;
          count_d    = WIDTH'(sat_clamp(int'(sum), int'(MAX)));
          if (count_d == '0) begin
            state_d         = EXPIRED;
            expired_pulse_d = 1'b1;
          end else begin
            state_d = pause_i ? PAUSED : RUNNING;
          end
        end
        EXPIRED: count_d = '0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      count_q         <= WIDTH'(INIT);
      expired_pulse_q <= 1'b0;
      sec_tick_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      expired_pulse_q <= expired_pulse_d;
      sec_tick_q      <= sec_tick_d;
    end
  end

  always_comb begin
    count_o         = count_q;
    running_o       = (state_q == RUNNING);
    paused_o        = (state_q == PAUSED);
    expired_o       = (state_q == EXPIRED);
    expired_pulse_o = expired_pulse_q;
    sec_tick_o      = sec_tick_q;
    warn_o          = ((state_q == RUNNING) || (state_q == PAUSED)) && (count_q != '0) &&
                      (count_q <= WIDTH'(WARN_THRESH));
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with a short prescaler and small count range.
module tb_game_countdown_timer;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, pause, adj_up, adj_down;
  logic [STEP_W-1:0] adj_amt;
  logic [WIDTH-1:0]  count;
  logic              running, paused, expired, expired_pulse, sec_tick, warn;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks;

  game_countdown_timer #(
    .WIDTH      (WIDTH),
    .INIT       (3),
    .MAX        (15),
    .TICK_DIV   (4),
    .STEP_W     (STEP_W),
    .WARN_THRESH(2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .pause_i        (pause),
    .adj_up_i       (adj_up),
    .adj_down_i     (adj_down),
    .adj_amt_i      (adj_amt),
    .count_o        (count),
    .running_o      (running),
    .paused_o       (paused),
    .expired_o      (expired),
    .expired_pulse_o(expired_pulse),
    .sec_tick_o     (sec_tick),
    .warn_o         (warn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, counting sec_tick pulses seen after each edge.
  task automatic run(input int n, output int nt);
    nt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sec_tick) nt++;
    end
  endtask

  task automatic flags(input string tag, input int r, input int p, input int e, input int ep,
                       input int st, input int w);
    check({tag, ".running"}, int'(running), r);
    check({tag, ".paused"}, int'(paused), p);
    check({tag, ".expired"}, int'(expired), e);
    check({tag, ".exp_pulse"}, int'(expired_pulse), ep);
    check({tag, ".sec_tick"}, int'(sec_tick), st);
    check({tag, ".warn"}, int'(warn), w);
  endtask

  task automatic adj(input logic up, input logic dn, input int amt);
    adj_up   = up;
    adj_down = dn;
    adj_amt  = STEP_W'(amt);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    adj(1'b0, 1'b0, 0);
    #12;
    check("rst.count", int'(count), 3);
    flags("rst", 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    adj(1'b1, 1'b0, 5);
    step();
    check("idle_adj.count", int'(count), 3);
    adj(1'b0, 1'b0, 0);

    // Countdown 3 -> 0 with a tick every 4 cycles.
    start = 1'b1;
    step();
    start = 1'b0;
    check("start.count", int'(count), 3);
    flags("start", 1, 0, 0, 0, 0, 0);
    run(3, ticks);
    check("pre_tick1.ticks", ticks, 0);
    step();
    check("tick1.count", int'(count), 2);
    flags("tick1", 1, 0, 0, 0, 1, 1);
    run(4, ticks);
    check("tick2.ticks", ticks, 1);
    check("tick2.count", int'(count), 1);
    check("tick2.warn", int'(warn), 1);
    run(3, ticks);
    check("pre_tick3.ticks", ticks, 0);
    step();
    check("tick3.count", int'(count), 0);
    flags("tick3", 0, 0, 1, 1, 1, 0);
    step();
    check("exp_hold.count", int'(count), 0);
    flags("exp_hold", 0, 0, 1, 0, 0, 0);

    // Restart from EXPIRED, then pause mid-period with the prescaler at 2.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart.count", int'(count), 3);
    check("restart.running", int'(running), 1);
    run(2, ticks);
    pause = 1'b1;
    run(6, ticks);
    check("pause.ticks", ticks, 0);
    check("pause.count", int'(count), 3);
    check("pause.paused", int'(paused), 1);
    pause = 1'b0;
    run(2, ticks);
    check("resume.early_ticks", ticks, 0);
    check("resume.running", int'(running), 1);
    step();
    check("resume.sec_tick", int'(sec_tick), 1);
    check("resume.count", int'(count), 2);

    // Saturation and the both-flags rule (prescaler 0 -> 1 -> 2 -> 3, no ticks).
    adj(1'b1, 1'b0, 12);
    step();
    check("adj12.count", int'(count), 14);
    adj(1'b1, 1'b0, 5);
    step();
    check("sat.count", int'(count), 15);
    adj(1'b1, 1'b1, 5);
    step();
    check("both.count", int'(count), 15);
    adj(1'b0, 1'b0, 0);
    step();
    check("tick_at_max.count", int'(count), 14);
    check("tick_at_max.sec_tick", int'(sec_tick), 1);

    // Bring count to 3, zero-amount adjust, then tick combined with +2.
    adj(1'b0, 1'b1, 11);
    step();
    check("down11.count", int'(count), 3);
    adj(1'b0, 1'b1, 0);
    step();
    check("amt0.count", int'(count), 3);
    check("amt0.exp_pulse", int'(expired_pulse), 0);
    adj(1'b0, 1'b0, 0);
    step();
    adj(1'b1, 1'b0, 2);
    step();
    check("combined.count", int'(count), 4);
    check("combined.sec_tick", int'(sec_tick), 1);

    // Penalty to below zero while paused expires immediately.
    pause = 1'b1;
    adj(1'b0, 1'b1, 2);
    step();
    check("paused2.count", int'(count), 2);
    check("paused2.paused", int'(paused), 1);
    check("paused2.warn", int'(warn), 1);
    adj(1'b0, 1'b1, 7);
    step();
    check("under.count", int'(count), 0);
    flags("under", 0, 0, 1, 1, 0, 0);
    pause = 1'b0;
    adj(1'b1, 1'b0, 5);
    step();
    check("exp_adj.count", int'(count), 0);
    check("exp_adj.expired", int'(expired), 1);
    check("exp_adj.exp_pulse", int'(expired_pulse), 0);
    adj(1'b0, 1'b0, 0);

    // Asynchronous reset mid-run at count 1.
    start = 1'b1;
    step();
    start = 1'b0;
    run(8, ticks);
    check("pre_rst.ticks", ticks, 2);
    check("pre_rst.count", int'(count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.count", int'(count), 3);
    flags("async_rst", 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst.count", int'(count), 3);
    check("post_rst.exp_pulse", int'(expired_pulse), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
